// File: rtl/board_video_reader.sv
// Copies the 42-cell Connect-4 board from dmem port 1 into a shadow buffer during
// vertical blanking, commits it atomically, and renders the board as RGB from it.
//   state  | meaning
//   IDLE   | waiting for the (x=0, y=480) blanking trigger, addr1 parked at cell 0
//   FETCH  | one dmem read per cycle, cells 0..41 captured into the shadow buffer
//   COMMIT | shadow copied to display buffer, frame_done pulses next cycle
module board_video_reader #(
  parameter logic [31:0] BOARD_BASE = 32'h0000_0100,
  parameter int          X0         = 96,
  parameter int          Y0         = 48
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        blank_b,
  output logic [31:0] addr1,
  input  logic [31:0] rd1,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [9:0] X_LO = 10'(X0);
  localparam logic [9:0] X_HI = 10'(X0 + 448);
  localparam logic [9:0] Y_LO = 10'(Y0);
  localparam logic [9:0] Y_HI = 10'(Y0 + 384);
  localparam logic [5:0] LAST_IDX = 6'd41;

  state_t            state;
  logic [5:0]        idx;
  logic [41:0][1:0]  shadow_buf;
  logic [41:0][1:0]  disp_buf;

  logic              trigger;
  logic [9:0]        ox, oy;
  logic              in_board;
  logic [5:0]        lx, ly, adx, ady;
  logic [11:0]       dist2;
  logic [5:0]        cell_idx;
  logic [1:0]        code;
  logic [23:0]       pix;
  logic              unused_bits;

  assign trigger = (y == 10'd480) && (x == 10'd0);
  assign addr1   = BOARD_BASE + {24'd0, idx, 2'b00};
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= 6'd0;
      shadow_buf <= '0;
      disp_buf   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          idx <= 6'd0;
          if (trigger) state <= FETCH;
        end
        FETCH: begin
          shadow_buf[idx] <= rd1[1:0];
          if (idx == LAST_IDX) begin
            idx   <= 6'd0;
            state <= COMMIT;
          end else begin
            idx <= idx + 6'd1;
          end
        end
        COMMIT: begin
          disp_buf   <= shadow_buf;
          frame_done <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Distance test uses |d| so squares stay unsigned; |d| never exceeds 32.
  always_comb begin
    ox       = x - X_LO;
    oy       = y - Y_LO;
    in_board = (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);
    lx       = ox[5:0];
    ly       = oy[5:0];
    adx      = lx[5] ? {1'b0, lx[4:0]} : (6'd32 - lx);
    ady      = ly[5] ? {1'b0, ly[4:0]} : (6'd32 - ly);
    dist2    = ({6'd0, adx} * {6'd0, adx}) + ({6'd0, ady} * {6'd0, ady});
    cell_idx = ({3'd0, oy[8:6]} * 6'd7) + {3'd0, ox[8:6]};
    code     = in_board ? disp_buf[cell_idx] : 2'd0;
    pix      = 24'h000000;
    if (enable && blank_b && in_board) begin
      if (dist2 <= 12'd784) begin
        case (code)
          2'd0:    pix = 24'hFFFFFF;
          2'd1:    pix = 24'hFF0000;
          2'd2:    pix = 24'hFFFF00;
          default: pix = 24'h00FF00;
        endcase
      end else begin
        pix = 24'h0000FF;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r <= 8'd0;
      g <= 8'd0;
      b <= 8'd0;
    end else begin
      r <= pix[23:16];
      g <= pix[15:8];
      b <= pix[7:0];
    end
  end

  // Cell code lives in rd1[1:0]; the offsets never reach bit 9 inside the board.
  assign unused_bits = ^{rd1[31:2], ox[9], oy[9]};

endmodule

// File: tb/tb_board_video_reader.sv
// Directed bench for board_video_reader: fetch sequencing, commit timing,
// rendering colours/bounds, tear-free update and reset during a fetch.
module tb_board_video_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [9:0]  x, y;
  logic        blank_b;
  logic [31:0] addr1;
  logic [31:0] rd1;
  logic [7:0]  r, g, b;
  logic        busy;
  logic        frame_done;

  logic [1:0]  mem [42];
  int          ai;
  int          n_total = 0;
  int          n_pass  = 0;
  int          fd_cnt  = 0;
  int          fd_mark;

  board_video_reader dut (
    .clk(clk), .reset(reset), .enable(enable), .x(x), .y(y), .blank_b(blank_b),
    .addr1(addr1), .rd1(rd1), .r(r), .g(g), .b(b), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // dmem port 1: combinational read, junk in the upper bits
  always_comb begin
    ai  = 0;
    rd1 = 32'hDEAD_BEEC;
    if (addr1 >= 32'h100 && addr1 < 32'h1A8 && addr1[1:0] == 2'b00) begin
      ai  = int'((addr1 - 32'h100) >> 2);
      rd1 = {30'h15555555, mem[ai]};
    end
  end

  always @(negedge clk) if (frame_done) fd_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input int px, input int py);
    x = 10'(px);
    y = 10'(py);
    step();
  endtask

  // Trigger, then walk the full fetch/commit; pixel (128,80) is shown meanwhile.
  task automatic do_fetch(input string tag, input logic [23:0] old_pix);
    fd_mark = fd_cnt;
    x = 10'd0; y = 10'd480;
    step();
    x = 10'd128; y = 10'd80;
    for (int i = 0; i < 42; i++) begin
      check($sformatf("%s_addr%0d", tag, i), addr1, 32'h100 + 32'(4 * i));
      check($sformatf("%s_busy%0d", tag, i), {31'd0, busy}, 32'd1);
      step();
    end
    check({tag, "_commit_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_commit_fd"}, {31'd0, frame_done}, 32'd0);
    check({tag, "_commit_rgb"}, {8'd0, r, g, b}, {8'd0, old_pix});
    step();
    check({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done_fd"}, {31'd0, frame_done}, 32'd1);
    check({tag, "_done_rgb"}, {8'd0, r, g, b}, {8'd0, old_pix});
    step();
    check({tag, "_after_fd"}, {31'd0, frame_done}, 32'd0);
    check({tag, "_fd_count"}, 32'(fd_cnt), 32'(fd_mark + 1));
  endtask

  initial begin
    for (int i = 0; i < 42; i++) mem[i] = 2'(i % 4);
    reset = 1'b0; enable = 1'b1; blank_b = 1'b1;
    x = 10'd100; y = 10'd60;
    #12;
    check("rst_rgb", {8'd0, r, g, b}, 32'h0);
    check("rst_addr", addr1, 32'h100);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fd", {31'd0, frame_done}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    step();
    check("rst_pix_100_60", {8'd0, r, g, b}, 32'h0000FF);

    do_fetch("f1", 24'hFFFFFF);
    check("c0_white", {8'd0, r, g, b}, 32'hFFFFFF);
    x = 10'd192;
    #1;
    check("latency_hold", {8'd0, r, g, b}, 32'hFFFFFF);
    step();
    check("c1_red", {8'd0, r, g, b}, 32'hFF0000);
    pixel(256, 80);  check("c2_yellow", {8'd0, r, g, b}, 32'hFFFF00);
    pixel(320, 80);  check("c3_green", {8'd0, r, g, b}, 32'h00FF00);
    pixel(128, 144); check("c7_green", {8'd0, r, g, b}, 32'h00FF00);
    pixel(512, 400); check("c41_red", {8'd0, r, g, b}, 32'hFF0000);
    pixel(100, 52);  check("corner_blue", {8'd0, r, g, b}, 32'h0000FF);
    pixel(156, 80);  check("disc_edge_in", {8'd0, r, g, b}, 32'hFFFFFF);
    pixel(157, 80);  check("disc_edge_out", {8'd0, r, g, b}, 32'h0000FF);
    pixel(100, 80);  check("disc_left_in", {8'd0, r, g, b}, 32'hFFFFFF);
    pixel(95, 80);   check("left_out", {8'd0, r, g, b}, 32'h0);
    pixel(544, 80);  check("right_out", {8'd0, r, g, b}, 32'h0);
    pixel(543, 80);  check("right_in", {8'd0, r, g, b}, 32'h0000FF);
    pixel(128, 432); check("bottom_out", {8'd0, r, g, b}, 32'h0);
    pixel(128, 431); check("bottom_in", {8'd0, r, g, b}, 32'h0000FF);
    blank_b = 1'b0;
    pixel(128, 80);  check("blank_black", {8'd0, r, g, b}, 32'h0);
    blank_b = 1'b1;
    enable = 1'b0;
    pixel(128, 80);  check("disable_black", {8'd0, r, g, b}, 32'h0);
    enable = 1'b1;
    pixel(128, 80);  check("reenable_white", {8'd0, r, g, b}, 32'hFFFFFF);

    pixel(128, 200);
    mem[0] = 2'd2;
    pixel(128, 80);  check("tear_hold", {8'd0, r, g, b}, 32'hFFFFFF);
    repeat (5) step();
    check("tear_hold2", {8'd0, r, g, b}, 32'hFFFFFF);
    do_fetch("f2", 24'hFFFFFF);
    check("tear_new", {8'd0, r, g, b}, 32'hFFFF00);

    fd_mark = fd_cnt;
    x = 10'd0; y = 10'd480;
    step();
    x = 10'd128; y = 10'd80;
    repeat (19) step();
    check("mid_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_addr", addr1, 32'h100);
    check("mid_rgb", {8'd0, r, g, b}, 32'h0);
    step();
    reset = 1'b1;
    step();
    check("mid_c0_empty", {8'd0, r, g, b}, 32'hFFFFFF);
    pixel(192, 80);  check("mid_c1_empty", {8'd0, r, g, b}, 32'hFFFFFF);
    pixel(128, 80);
    repeat (50) step();
    check("mid_no_fd", 32'(fd_cnt), 32'(fd_mark));
    check("mid_idle", {31'd0, busy}, 32'd0);
    do_fetch("f3", 24'hFFFFFF);
    check("f3_c0_yellow", {8'd0, r, g, b}, 32'hFFFF00);
    pixel(192, 80);  check("f3_c1_red", {8'd0, r, g, b}, 32'hFF0000);
    pixel(128, 144); check("f3_c7_green", {8'd0, r, g, b}, 32'h00FF00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
